// File: rtl/oflow_frame_sequencer_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : oflow_frame_seq_pkg
//  Description : Shared constants, state encoding and set-count helper for
//                the optical-flow frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package oflow_frame_seq_pkg;

   localparam int PE_NUM                = 8;
   localparam int SET_LEN               = 4;
   localparam int OBJ_NUM_WIDTH         = 7;
   localparam int MAX_OBJECTS           = 64;
   localparam int TOTAL_FRAME_NUM_WIDTH = 16;
   localparam int PE_SHIFT              = $clog2(PE_NUM);

   typedef enum logic [2:0] {
      FS_IDLE      = 3'd0,
      FS_FE_START  = 3'd1,
      FS_FE_WAIT   = 3'd2,
      FS_REG_START = 3'd3,
      FS_REG_WAIT  = 3'd4,
      FS_DONE      = 3'd5
   } frame_seq_state_t;

   // ceil(n / PE_NUM): PE_NUM is a power of two, so this is a shift plus a
   // round-up whenever any remainder bit is set. One guard bit is kept.
   function automatic logic [SET_LEN-1:0] ceil_div_pe(input logic [OBJ_NUM_WIDTH-1:0] n);
      logic [OBJ_NUM_WIDTH:0] w_ext;
      logic [OBJ_NUM_WIDTH:0] w_quot;
      w_ext  = {1'b0, n};
      w_quot = (w_ext >> PE_SHIFT) + {{OBJ_NUM_WIDTH{1'b0}}, |w_ext[PE_SHIFT-1:0]};
      return w_quot[SET_LEN-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/oflow_frame_sequencer_fsm_if.sv
`default_nettype none
// ============================================================================
//  Interface   : oflow_frame_sequencer_fsm_if
//  Description : Frame request, PE-array and registration handshakes plus
//                status outputs of the frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface oflow_frame_sequencer_fsm_if;
   import oflow_frame_seq_pkg::*;

   logic                             start_frame;
   logic [OBJ_NUM_WIDTH-1:0]         num_of_objects;
   logic                             start_feature_extraction;
   logic                             done_feature_extraction;
   logic                             start_registration;
   logic                             done_registration;
   logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num;
   logic [SET_LEN-1:0]               num_of_sets;
   logic                             busy;
   logic                             frame_done;
   logic                             start_ignored;
   logic                             obj_overflow;

   // Driver of frame requests and done pulses
   modport master (
      output start_frame, num_of_objects, done_feature_extraction, done_registration,
      input  start_feature_extraction, start_registration, frame_num, num_of_sets,
             busy, frame_done, start_ignored, obj_overflow
   );

   // The sequencer itself
   modport slave (
      input  start_frame, num_of_objects, done_feature_extraction, done_registration,
      output start_feature_extraction, start_registration, frame_num, num_of_sets,
             busy, frame_done, start_ignored, obj_overflow
   );

endinterface
`default_nettype wire

// File: rtl/oflow_frame_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_frame_seq_counter
//  Description : Saturating frame counter with load and increment enable.
//                Never wraps back to zero once all-ones is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
module oflow_frame_seq_counter
   import oflow_frame_seq_pkg::*;
#(
   parameter int WIDTH = TOTAL_FRAME_NUM_WIDTH
) (
   input  wire logic             clk,
   input  wire logic             reset_N,
   input  wire logic             load_en,
   input  wire logic [WIDTH-1:0] load_value,
   input  wire logic             inc_en,
   output logic      [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   // Load has priority; increments stop at all-ones
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         r_count <= '0;
      end else if (load_en) begin
         r_count <= load_value;
      end else if (inc_en && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/oflow_frame_sequencer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_frame_sequencer_fsm
//  Description : Per-frame sequencer: feature extraction, then registration,
//                then frame completion and frame counter advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module oflow_frame_sequencer_fsm
   import oflow_frame_seq_pkg::*;
(
   input wire logic                   clk,
   input wire logic                   reset_N,
   oflow_frame_sequencer_fsm_if.slave bus
);

   localparam logic [2:0] S_IDLE      = FS_IDLE;
   localparam logic [2:0] S_FE_START  = FS_FE_START;
   localparam logic [2:0] S_FE_WAIT   = FS_FE_WAIT;
   localparam logic [2:0] S_REG_START = FS_REG_START;
   localparam logic [2:0] S_REG_WAIT  = FS_REG_WAIT;
   localparam logic [2:0] S_DONE      = FS_DONE;

   logic [2:0]                       r_state;
   logic [SET_LEN-1:0]               r_num_of_sets;
   logic                             r_empty_frame;
   logic                             r_start_ignored;
   logic                             r_obj_overflow;
   logic                             w_obj_zero;
   logic                             w_obj_over;
   logic                             w_frame_inc;
   logic [TOTAL_FRAME_NUM_WIDTH-1:0] w_frame_num;

   assign w_obj_zero = (bus.num_of_objects == '0);
   assign w_obj_over = (int'(bus.num_of_objects) > MAX_OBJECTS);

   // Frame state machine, set count latch and sticky overflow flag
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         r_state        <= S_IDLE;
         r_num_of_sets  <= '0;
         r_empty_frame  <= 1'b0;
         r_obj_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start_frame) begin
                  if (w_obj_zero) begin
                     r_empty_frame <= 1'b1;
                     r_state       <= S_DONE;
                  end else if (w_obj_over) begin
                     r_obj_overflow <= 1'b1;
                  end else begin
                     r_empty_frame <= 1'b0;
                     r_num_of_sets <= ceil_div_pe(bus.num_of_objects);
                     r_state       <= S_FE_START;
                  end
               end
            end
            S_FE_START:  r_state <= S_FE_WAIT;
            S_FE_WAIT:   if (bus.done_feature_extraction) r_state <= S_REG_START;
            S_REG_START: r_state <= S_REG_WAIT;
            S_REG_WAIT:  if (bus.done_registration) r_state <= S_DONE;
            S_DONE:      r_state <= S_IDLE;
            default:     r_state <= S_IDLE;
         endcase
      end
   end

   // Rejection pulse: busy, or oversize request while idle
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         r_start_ignored <= 1'b0;
      end else begin
         r_start_ignored <= bus.start_frame && ((r_state != S_IDLE) || w_obj_over);
      end
   end

   // Count advances on the edge leaving DONE, empty frames excluded
   assign w_frame_inc = (r_state == S_DONE) && !r_empty_frame;

   oflow_frame_seq_counter #(
      .WIDTH (TOTAL_FRAME_NUM_WIDTH)
   ) u_frame_counter (
      .clk        (clk),
      .reset_N    (reset_N),
      .load_en    (1'b0),
      .load_value ({TOTAL_FRAME_NUM_WIDTH{1'b0}}),
      .inc_en     (w_frame_inc),
      .count      (w_frame_num)
   );

   assign bus.start_feature_extraction = (r_state == S_FE_START);
   assign bus.start_registration       = (r_state == S_REG_START);
   assign bus.frame_done               = (r_state == S_DONE);
   assign bus.busy                     = (r_state != S_IDLE);
   assign bus.frame_num                = w_frame_num;
   assign bus.num_of_sets              = r_num_of_sets;
   assign bus.start_ignored            = r_start_ignored;
   assign bus.obj_overflow             = r_obj_overflow;

endmodule
`default_nettype wire

// File: doc/oflow_frame_sequencer_fsm.md
Name: oflow_frame_sequencer_fsm

Overview:
- Per-frame control stage directly upstream of the registration FSM. It produces `frame_num`, `num_of_sets` and the `start_registration` pulse that block consumes.
- For each frame it first runs feature extraction across the PE array, then starts registration, then waits for registration to complete. After that it advances the frame counter and reports the frame as done.
- It owns the first-frame indication: `frame_num == 0` until the first non-empty frame completes.

Parameters:
- PE_NUM, 8, number of processing elements; objects per set.
- SET_LEN, 4, width of `num_of_sets`.
- OBJ_NUM_WIDTH, 7, width of `num_of_objects`.
- MAX_OBJECTS, 64, largest legal object count per frame; must be <= PE_NUM*(2^SET_LEN - 1).
- TOTAL_FRAME_NUM_WIDTH, 16, width of `frame_num`.

Ports:
- clk  in  1  system clock.
- reset_N  in  1  asynchronous active-low reset.
- start_frame  in  1  single-cycle request to process a new frame.
- num_of_objects  in  OBJ_NUM_WIDTH  object count; sampled when start_frame is accepted.
- start_feature_extraction  out  1  single-cycle pulse to the PE array.
- done_feature_extraction  in  1  single-cycle pulse from the PE array.
- start_registration  out  1  single-cycle pulse to the registration FSM.
- done_registration  in  1  single-cycle pulse from the registration FSM.
- frame_num  out  TOTAL_FRAME_NUM_WIDTH  count of completed non-empty frames.
- num_of_sets  out  SET_LEN  ceil(latched objects / PE_NUM).
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  single-cycle pulse when a frame finishes.
- start_ignored  out  1  single-cycle pulse when start_frame is rejected.
- obj_overflow  out  1  sticky; set when num_of_objects > MAX_OBJECTS; cleared only by reset.

Behaviour:
- Reset (asynchronous):
  - State returns to IDLE from any state.
  - All pulse outputs are 0; frame_num = 0; num_of_sets = 0; busy = 0; obj_overflow = 0.
- States: IDLE, FE_START, FE_WAIT, REG_START, REG_WAIT, DONE.
- IDLE:
  - On start_frame with 0 < num_of_objects <= MAX_OBJECTS: latch the object count, register num_of_sets = (n + PE_NUM - 1) / PE_NUM, go to FE_START.
  - num_of_sets is stable from the following cycle until the next accepted frame.
- Zero-object frame: on start_frame with num_of_objects == 0, go directly to DONE. No start pulses are issued and frame_num does not increment.
- Oversize frame: on start_frame with num_of_objects > MAX_OBJECTS, set obj_overflow, stay in IDLE, pulse start_ignored, and leave frame_num and num_of_sets unchanged.
- FE_START: start_feature_extraction = 1 for exactly one cycle, then go to FE_WAIT.
- FE_WAIT:
  - On done_feature_extraction, go to REG_START.
  - A done_feature_extraction arriving in any other state is ignored.
- REG_START:
  - start_registration = 1 for exactly one cycle, then go to REG_WAIT.
  - frame_num holds its pre-increment value for the whole registration. `frame_num == 0` selects the first-frame ID path in the registration FSM.
- REG_WAIT:
  - On done_registration, go to DONE.
  - A done_registration arriving in any other state is ignored.
- DONE:
  - frame_done = 1 for one cycle.
  - frame_num increments on the same edge that leaves DONE, only if the frame was non-empty. It saturates at all-ones and never wraps to 0, so the first-frame path is never re-entered.
  - Return to IDLE.
- start_frame in any state other than IDLE is rejected: pulse start_ignored; no other effect.
- Latency: start_frame accepted at edge T gives start_feature_extraction high during cycle T+1. A done pulse in a WAIT state at edge D gives the next start (or frame_done) high during cycle D+1.
- Minimum frame, with done pulses returned immediately: 5 cycles from accept to frame_done.
- Arithmetic:
  - The ceiling divide is computed in OBJ_NUM_WIDTH+1 bits before truncation to SET_LEN.
  - PE_NUM must be a power of two; the divide reduces to a shift plus an OR of the low bits.

Decomposition:
- Shared package oflow_frame_seq_pkg holds:
  - state enum frame_seq_state_t (6 states, 3 bits);
  - PE_NUM, SET_LEN, OBJ_NUM_WIDTH and MAX_OBJECTS constants, aligned with the existing core defines;
  - function ceil_div_pe().
- Sub-module oflow_frame_seq_counter holds frame_num with saturation and increment-enable. It is reused wherever a saturating frame counter is needed.
- The FSM and set computation stay in the top module.

Test Plan:
- Reset, then start_frame with num_of_objects = 13, PE_NUM = 8 -> num_of_sets = 2; start_feature_extraction one cycle later; start_registration with frame_num = 0; after done_registration, frame_done pulses and frame_num = 1.
- num_of_objects = 8, then 9, then 64 -> num_of_sets = 1, 2, 8 respectively; frame_num reaches 3.
- num_of_objects = 0 -> frame_done within 2 cycles; no start pulses; frame_num stays 0. A following 5-object frame still registers with frame_num = 0.
- num_of_objects = 65 -> start_ignored pulses, obj_overflow sticks at 1, FSM stays IDLE; a subsequent legal frame proceeds normally.
- start_frame during FE_WAIT, plus a stray done_registration during FE_WAIT -> start_ignored pulses; state unchanged; num_of_sets unchanged.
- Preload frame_num = 0xFFFF via the counter, run one frame -> frame_num stays 0xFFFF. Assert reset_N low during REG_WAIT -> immediate IDLE, all outputs 0.
